seg7_scan_ctrl: RTL and testbench
=================================

// Module: seg7_scan_ctrl
// PURPOSE
//  - Time-multiplexed scan controller for the 3-digit 7-segment counter display.
//  - Shares one 8-bit segment bus across NUM_DIGITS digits using one-hot digit enables.
//  - Inserts blanking dead-time between digits to prevent ghosting.
//  - Takes new digit patterns from the counter over a valid/ready handshake. Applies them
//    only at frame boundaries, so a frame never mixes old and new digits (no tearing).
// PARAMETERS
//  NUM_DIGITS    3     number of multiplexed digits (>=1)
//  DWELL_CYCLES  1000  clk cycles each digit is lit (>=1)
//  BLANK_CYCLES  50    clk cycles all digits off before each digit (>=0; 0 = no BLANK state)
//  DIG_ACT_LOW   1     1: dig_sel bit=0 lights that digit; 0: bit=1 lights it
// PORTS
//  clk        in   1             single system clock, rising edge
//  rst        in   1             synchronous reset, active-low (sampled on clk rising edge)
//  en         in   1             scan enable; 0 = display dark
//  seg_in     in   8*NUM_DIGITS  new frame; digit k at [8k+7:8k]; digit0 = least significant
//  upd_valid  in   1             seg_in valid
//  upd_ready  out  1             pending buffer free; transfer when upd_valid & upd_ready
//  seg_out    out  8             shared segment bus {a,b,c,d,e,f,g,dp}, 1 = lit ("0" = 8'hFC)
//  dig_sel    out  NUM_DIGITS    digit enables, polarity per DIG_ACT_LOW
//  frame_done out  1             1-cycle pulse at end of the last digit's dwell
// BEHAVIOUR
//  - Reset (rst=0):
//    - state=IDLE, idx=0, timer=0, pending empty.
//    - Every shadow digit = 8'hFC (shows "000").
//    - seg_out=0, dig_sel=all off, frame_done=0, upd_ready=1.
//  - All outputs are registered. Each output value reflects the state held in that cycle.
//  - FSM states: IDLE, BLANK, SHOW.
//    - IDLE: seg_out=0, dig_sel all off. en=1 -> BLANK with idx=0, timer=0.
//    - BLANK: seg_out=0, dig_sel all off. Lasts BLANK_CYCLES cycles, then -> SHOW with timer=0.
//    - SHOW: seg_out=shadow[idx], dig_sel lights only digit idx. Lasts DWELL_CYCLES cycles, then:
//      - idx==NUM_DIGITS-1: frame_done=1 on the last SHOW cycle; idx=0.
//      - otherwise: idx+1.
//      - Next state is BLANK, or SHOW directly when BLANK_CYCLES=0.
//  - Frame length is NUM_DIGITS*(BLANK_CYCLES+DWELL_CYCLES) cycles; 3150 with defaults.
//  - Frame boundary = the transition that starts the idx=0 slot (from IDLE or from wrap-around).
//    - At the boundary, if pending is full: shadow<=pending and pending becomes empty.
//  - Handshake:
//    - upd_ready = ~pending_full.
//    - Transfer (upd_valid & upd_ready) stores seg_in into pending and sets pending_full.
//    - A transfer in the boundary cycle itself waits for the following boundary.
//    - While pending is full, seg_in is ignored and upd_ready=0.
//    - upd_ready returns to 1 in the cycle after the boundary.
//  - en=0 in any state:
//    - Next cycle: IDLE, outputs dark, idx=0.
//    - Shadow and pending are retained; the handshake keeps working.
//    - Re-enable restarts at digit0. A full pending is loaded at that restart boundary.
//  - Timer width = clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1).
//  - Timer and idx wrap exactly at their terminal values. Never out of range.
//  - rst=0 mid-operation overrides all; pending data is discarded.
// STRUCTURE
//  - Shared include seg7_defs.vh:
//    - SEG_0..SEG_9 patterns (8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hE6).
//    - SEG_BLANK = 8'h00.
//    - FSM state encodings: IDLE=2'd0, BLANK=2'd1, SHOW=2'd2.
//  - One sub-module, seg7_frame_buf: pending + shadow registers and the handshake logic,
//    with a load strobe driven by the FSM.
//  - The FSM, timer and idx stay in the top module.
// TESTING (NUM_DIGITS=3, DWELL_CYCLES=4, BLANK_CYCLES=1, DIG_ACT_LOW=1)
//  1. Reset: rst=0 for 2 cycles, en=1
//     -> seg_out=8'h00, dig_sel=3'b111, upd_ready=1, frame_done=0.
//  2. Scan: rst=1, en=1, no update -> per digit: 1 cycle dark, then 4 cycles seg_out=8'hFC.
//     - dig_sel sequence: 110, 101, 011.
//     - frame_done pulses on cycle 15. The pattern repeats.
//  3. Update mid-frame: seg_in={8'h60,8'hDA,8'hF2} during the digit1 slot
//     -> current frame stays 8'hFC; upd_ready=0 until the boundary.
//     - Next frame: digit0=F2, digit1=DA, digit2=60. upd_ready=1 again.
//  4. Back-pressure: second upd_valid held while pending is full -> not accepted (ready=0).
//     - Accepted the cycle after the boundary; displayed one frame later.
//  5. en=0 during digit1 SHOW -> next cycle dig_sel=111, seg_out=00.
//     - en=1 -> 1 blank cycle, then digit0 (dig_sel=110).
//  6. rst=0 mid-frame with pending full -> all outputs at reset values.
//     - After release, digits show 8'hFC; the pending data is never displayed.

Source files
------------

// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared segment patterns and scan FSM state encoding for the 7-segment scan controller.
package seg7_scan_ctrl_pkg;

  localparam logic [7:0] SEG_0     = 8'hFC;
  localparam logic [7:0] SEG_1     = 8'h60;
  localparam logic [7:0] SEG_2     = 8'hDA;
  localparam logic [7:0] SEG_3     = 8'hF2;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'hB6;
  localparam logic [7:0] SEG_6     = 8'hBE;
  localparam logic [7:0] SEG_7     = 8'hE0;
  localparam logic [7:0] SEG_8     = 8'hFE;
  localparam logic [7:0] SEG_9     = 8'hE6;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

endpackage

// File: rtl/seg7_frame_buf.sv
// Pending/shadow frame registers with valid/ready intake; shadow is replaced only on a load strobe.
module seg7_frame_buf
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*NUM_DIGITS-1:0] seg_in,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  input  logic                    load,
  output logic [8*NUM_DIGITS-1:0] shadow_d
);

  logic [8*NUM_DIGITS-1:0] pending_q, pending_d;
  logic [8*NUM_DIGITS-1:0] shadow_q;
  logic                    pending_full_q, pending_full_d;

  assign upd_ready = ~pending_full_q;

  // Intake is blocked while full, so a load and a transfer never coincide.
  always_comb begin
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    shadow_d       = shadow_q;
    if (load && pending_full_q) begin
      shadow_d       = pending_q;
      pending_full_d = 1'b0;
    end else if (upd_valid && !pending_full_q) begin
      pending_d      = seg_in;
      pending_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      shadow_q       <= {NUM_DIGITS{SEG_0}};
    end else begin
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      shadow_q       <= shadow_d;
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with blanking dead-time and tear-free frame updates.
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 3,
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned BLANK_CYCLES = 50,
  parameter bit          DIG_ACT_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [8*NUM_DIGITS-1:0] seg_in,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_done
);

  localparam int unsigned TMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam state_e        SLOT_START = (BLANK_CYCLES > 0) ? ST_BLANK : ST_SHOW;

  state_e                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    load;
  logic [8*NUM_DIGITS-1:0] shadow_d;

  logic [7:0]              seg_out_q, seg_out_d;
  logic [NUM_DIGITS-1:0]   dig_sel_q, dig_sel_d;
  logic                    frame_done_q, frame_done_d;
  logic [NUM_DIGITS-1:0]   dig_on;

  seg7_frame_buf #(
    .NUM_DIGITS(NUM_DIGITS)
  ) u_frame_buf (
    .clk      (clk),
    .rst      (rst),
    .seg_in   (seg_in),
    .upd_valid(upd_valid),
    .upd_ready(upd_ready),
    .load     (load),
    .shadow_d (shadow_d)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    load    = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      timer_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = SLOT_START;
          idx_d   = '0;
          timer_d = '0;
          load    = 1'b1;
        end
        ST_BLANK: begin
          if (timer_q == BLANK_LAST) begin
            state_d = ST_SHOW;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        ST_SHOW: begin
          if (timer_q == DWELL_LAST) begin
            state_d = SLOT_START;
            timer_d = '0;
            if (idx_q == IDX_LAST) begin
              idx_d = '0;
              load  = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
          timer_d = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from next-cycle state and shadow so the registers match the state they accompany.
  always_comb begin
    seg_out_d    = SEG_BLANK;
    dig_on       = '0;
    frame_done_d = 1'b0;
    if (state_d == ST_SHOW) begin
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        if (idx_d == IW'(k)) begin
          dig_on[k] = 1'b1;
          seg_out_d = shadow_d[8*k +: 8];
        end
      end
      frame_done_d = (idx_d == IDX_LAST) && (timer_d == DWELL_LAST);
    end
    dig_sel_d = DIG_ACT_LOW ? ~dig_on : dig_on;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      timer_q      <= '0;
      seg_out_q    <= SEG_BLANK;
      dig_sel_q    <= {NUM_DIGITS{DIG_ACT_LOW}};
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      timer_q      <= timer_d;
      seg_out_q    <= seg_out_d;
      dig_sel_q    <= dig_sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_out    = seg_out_q;
  assign dig_sel    = dig_sel_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed self-checking bench for seg7_scan_ctrl (3 digits, dwell 4, blank 1, active-low digits).
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [23:0] seg_in;
  logic        upd_valid;
  logic        upd_ready;
  logic [7:0]  seg_out;
  logic [2:0]  dig_sel;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;
  int n     = 0;

  logic [7:0] fa [3];
  logic [7:0] fb [3];
  logic [7:0] fc [3];

  seg7_scan_ctrl #(
    .NUM_DIGITS  (3),
    .DWELL_CYCLES(4),
    .BLANK_CYCLES(1),
    .DIG_ACT_LOW (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .seg_in    (seg_in),
    .upd_valid (upd_valid),
    .upd_ready (upd_ready),
    .seg_out   (seg_out),
    .dig_sel   (dig_sel),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    n++;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; upd_valid = 1'b0; seg_in = '0;
    tick(); tick();
    n_cmp++; if (seg_out !== 8'h00) begin n_bad++; $display("FAIL reset_seg got=%h want=00", seg_out); end
    n_cmp++; if (dig_sel !== 3'b111) begin n_bad++; $display("FAIL reset_dig got=%b want=111", dig_sel); end
    n_cmp++; if (upd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b want=1", upd_ready); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_fd got=%b want=0", frame_done); end
    rst = 1'b1;
    n = 0;
  endtask

  task automatic test_scan();
    int f, s, p;
    logic [2:0] exp_dig;
    logic [7:0] exp_seg;
    logic       exp_fd;
    for (int i = 0; i < 30; i++) begin
      tick();
      f = (n - 1) % 15; s = f / 5; p = f % 5;
      exp_dig = (p == 0) ? 3'b111 : ~(3'b001 << s);
      exp_seg = (p == 0) ? 8'h00 : 8'hFC;
      exp_fd  = (f == 14);
      n_cmp++; if (dig_sel !== exp_dig) begin n_bad++; $display("FAIL scan_dig n=%0d got=%b want=%b", n, dig_sel, exp_dig); end
      n_cmp++; if (seg_out !== exp_seg) begin n_bad++; $display("FAIL scan_seg n=%0d got=%h want=%h", n, seg_out, exp_seg); end
      n_cmp++; if (frame_done !== exp_fd) begin n_bad++; $display("FAIL scan_fd n=%0d got=%b want=%b", n, frame_done, exp_fd); end
      n_cmp++; if (upd_ready !== 1'b1) begin n_bad++; $display("FAIL scan_ready n=%0d got=%b want=1", n, upd_ready); end
    end
  endtask

  task automatic test_update();
    int f, s, p;
    logic [7:0] exp_seg;
    logic       exp_rdy;
    while (n < 36) tick();
    seg_in = {8'h60, 8'hDA, 8'hF2};
    upd_valid = 1'b1;
    for (int i = 37; i <= 60; i++) begin
      tick();
      f = (n - 1) % 15; s = f / 5; p = f % 5;
      exp_seg = (p == 0) ? 8'h00 : ((n >= 46) ? fa[s] : 8'hFC);
      exp_rdy = !(n >= 37 && n <= 45);
      n_cmp++; if (seg_out !== exp_seg) begin n_bad++; $display("FAIL upd_seg n=%0d got=%h want=%h", n, seg_out, exp_seg); end
      n_cmp++; if (upd_ready !== exp_rdy) begin n_bad++; $display("FAIL upd_ready n=%0d got=%b want=%b", n, upd_ready, exp_rdy); end
      if (n == 37) upd_valid = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int f, s, p, fr;
    logic [7:0] exp_seg;
    logic       exp_rdy;
    seg_in = {8'hE0, 8'hFE, 8'hE6};
    upd_valid = 1'b1;
    for (int i = 61; i <= 105; i++) begin
      tick();
      f = (n - 1) % 15; s = f / 5; p = f % 5; fr = (n - 1) / 15;
      if (p == 0) exp_seg = 8'h00;
      else if (fr == 4) exp_seg = fa[s];
      else if (fr == 5) exp_seg = fb[s];
      else exp_seg = fc[s];
      exp_rdy = !((n >= 61 && n <= 75) || (n >= 77 && n <= 90));
      n_cmp++; if (seg_out !== exp_seg) begin n_bad++; $display("FAIL bp_seg n=%0d got=%h want=%h", n, seg_out, exp_seg); end
      n_cmp++; if (upd_ready !== exp_rdy) begin n_bad++; $display("FAIL bp_ready n=%0d got=%b want=%b", n, upd_ready, exp_rdy); end
      if (n == 61) seg_in = {8'hBE, 8'h66, 8'hB6};
      if (n == 77) upd_valid = 1'b0;
    end
  endtask

  task automatic test_enable();
    while (n < 113) tick();
    n_cmp++; if (seg_out !== 8'h66 || dig_sel !== 3'b101) begin n_bad++; $display("FAIL en_pre n=%0d got=%h/%b want=66/101", n, seg_out, dig_sel); end
    en = 1'b0;
    tick();
    n_cmp++; if (dig_sel !== 3'b111) begin n_bad++; $display("FAIL en_off_dig got=%b want=111", dig_sel); end
    n_cmp++; if (seg_out !== 8'h00) begin n_bad++; $display("FAIL en_off_seg got=%h want=00", seg_out); end
    seg_in = {8'hFC, 8'hE6, 8'h60};
    upd_valid = 1'b1;
    tick();
    n_cmp++; if (upd_ready !== 1'b0) begin n_bad++; $display("FAIL en_off_xfer got=%b want=0", upd_ready); end
    n_cmp++; if (dig_sel !== 3'b111 || seg_out !== 8'h00) begin n_bad++; $display("FAIL en_off_dark got=%b/%h want=111/00", dig_sel, seg_out); end
    upd_valid = 1'b0;
    en = 1'b1;
    tick();
    n_cmp++; if (dig_sel !== 3'b111 || seg_out !== 8'h00) begin n_bad++; $display("FAIL en_blank got=%b/%h want=111/00", dig_sel, seg_out); end
    n_cmp++; if (upd_ready !== 1'b1) begin n_bad++; $display("FAIL en_load_ready got=%b want=1", upd_ready); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (dig_sel !== 3'b110 || seg_out !== 8'h60) begin n_bad++; $display("FAIL en_d0 i=%0d got=%b/%h want=110/60", i, dig_sel, seg_out); end
    end
    tick();
    n_cmp++; if (dig_sel !== 3'b111 || seg_out !== 8'h00) begin n_bad++; $display("FAIL en_gap got=%b/%h want=111/00", dig_sel, seg_out); end
    tick();
    n_cmp++; if (dig_sel !== 3'b101 || seg_out !== 8'hE6) begin n_bad++; $display("FAIL en_d1 got=%b/%h want=101/E6", dig_sel, seg_out); end
  endtask

  task automatic test_reset_mid();
    int f, s, p;
    logic [2:0] exp_dig;
    logic [7:0] exp_seg;
    seg_in = {8'hE0, 8'hE0, 8'hE0};
    upd_valid = 1'b1;
    tick();
    upd_valid = 1'b0;
    n_cmp++; if (upd_ready !== 1'b0) begin n_bad++; $display("FAIL rstm_full got=%b want=0", upd_ready); end
    rst = 1'b0;
    tick();
    n_cmp++; if (seg_out !== 8'h00) begin n_bad++; $display("FAIL rstm_seg got=%h want=00", seg_out); end
    n_cmp++; if (dig_sel !== 3'b111) begin n_bad++; $display("FAIL rstm_dig got=%b want=111", dig_sel); end
    n_cmp++; if (upd_ready !== 1'b1) begin n_bad++; $display("FAIL rstm_ready got=%b want=1", upd_ready); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL rstm_fd got=%b want=0", frame_done); end
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      f = (n - 1) % 15; s = f / 5; p = f % 5;
      exp_dig = (p == 0) ? 3'b111 : ~(3'b001 << s);
      exp_seg = (p == 0) ? 8'h00 : 8'hFC;
      n_cmp++; if (dig_sel !== exp_dig) begin n_bad++; $display("FAIL rstm_scan_dig n=%0d got=%b want=%b", n, dig_sel, exp_dig); end
      n_cmp++; if (seg_out !== exp_seg) begin n_bad++; $display("FAIL rstm_scan_seg n=%0d got=%h want=%h", n, seg_out, exp_seg); end
    end
  endtask

  initial begin
    fa[0] = 8'hF2; fa[1] = 8'hDA; fa[2] = 8'h60;
    fb[0] = 8'hE6; fb[1] = 8'hFE; fb[2] = 8'hE0;
    fc[0] = 8'hB6; fc[1] = 8'h66; fc[2] = 8'hBE;
    test_reset();
    test_scan();
    test_update();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
